csr_arbiter: RTL
================

CSR_ARBITER -- requirements
Module: csr_arbiter

Interface
REQ-001 Parameter NR_REQ, default 2: number of CSR requesters (2..8).
REQ-002 Parameter XLEN, default 64: CSR write-data width.
REQ-003 Parameter TIMEOUT, default 64: commit watchdog limit in cycles (>=2).
REQ-004 clk_i  in  1  sole clock; all state updates on rising edge.
REQ-005 rst_i  in  1  reset, synchronous, active-high.
REQ-006 flush_i  in  1  pipeline flush; abandons any pending op.
REQ-007 req_valid_i  in  NR_REQ  per-requester request valid.
REQ-008 req_ready_o  out  NR_REQ  one-hot accept strobe for the winning requester.
REQ-009 req_addr_i  in  NR_REQ*12  per-requester CSR address, packed; requester i at bits [12i+11:12i].
REQ-010 req_wdata_i  in  NR_REQ*XLEN  per-requester write data, packed by the same rule.
REQ-011 csr_valid_o  out  1  op valid toward the single-entry CSR buffer.
REQ-012 csr_ready_i  in  1  CSR buffer ready.
REQ-013 csr_addr_o  out  12  latched CSR address.
REQ-014 csr_wdata_o  out  XLEN  latched write data.
REQ-015 csr_commit_i  in  1  commit of the pending CSR op.
REQ-016 grant_id_o  out  $clog2(NR_REQ)  index of the current owner.
REQ-017 busy_o  out  1  high whenever the FSM is not IDLE.
REQ-018 timeout_o  out  1  single-cycle pulse when the watchdog expires.

Function
REQ-019 The FSM SHALL have states IDLE, ISSUE and WAIT_COMMIT; at most one CSR op SHALL be outstanding.
REQ-020 IDLE with any req_valid_i set: winner = first set bit searching upward from rr_q with wrap; req_ready_o[winner]=1 combinationally in that cycle; addr/wdata/winner latched; next state ISSUE.
REQ-021 req_ready_o SHALL be all-zero outside IDLE and when no request is present.
REQ-022 ISSUE: csr_valid_o=1; on csr_ready_i=1 -> WAIT_COMMIT, watchdog cleared to 0.
REQ-023 Latency: request accepted in cycle N -> csr_valid_o high in cycle N+1.
REQ-024 csr_addr_o, csr_wdata_o and grant_id_o SHALL hold their latched values, stable from acceptance until return to IDLE.
REQ-025 WAIT_COMMIT: watchdog increments by 1 each cycle; csr_commit_i=1 -> IDLE and rr_q = (winner+1) mod NR_REQ.
REQ-026 WAIT_COMMIT with watchdog == TIMEOUT-1 and no commit: timeout_o=1 for that cycle, -> IDLE, rr_q advanced per REQ-025.
REQ-027 Commit and watchdog expiry in the same cycle: commit wins, timeout_o stays 0.
REQ-028 csr_commit_i in IDLE or ISSUE SHALL be ignored.
REQ-029 flush_i=1 in any state -> IDLE next cycle; watchdog cleared; rr_q unchanged; timeout_o=0; req_ready_o forced all-zero that cycle.
REQ-030 flush_i has priority over commit, timeout and a new acceptance in the same cycle.
REQ-031 Back-to-back: commit in cycle k -> IDLE in k+1 -> next acceptance possible in k+1 -> csr_valid_o in k+2.

Reset
REQ-032 rst_i=1 at a clock edge SHALL force: state IDLE, rr_q=0, watchdog=0, latched addr/wdata/winner=0.
REQ-033 While in reset, and in the first cycle after it: csr_valid_o=0, req_ready_o=0, busy_o=0, timeout_o=0, csr_addr_o=0, csr_wdata_o=0, grant_id_o=0.
REQ-034 rst_i asserted mid-op (ISSUE or WAIT_COMMIT) SHALL abandon the op without a timeout pulse and without advancing rr_q.

Verification
REQ-035 req_valid_i=2'b11 after reset -> req_ready_o=2'b01, grant_id_o=0; csr_valid_o high next cycle with requester-0 addr.
REQ-036 Both requesters held valid, commits issued promptly -> grants alternate 0,1,0,1; csr_valid_o rises 2 cycles after each commit.
REQ-037 csr_ready_i held 0 for 5 cycles in ISSUE -> csr_valid_o, csr_addr_o and csr_wdata_o stay stable; WAIT_COMMIT is entered on the first csr_ready_i=1.
REQ-038 TIMEOUT=64, no commit -> timeout_o pulses exactly once, 64 cycles after WAIT_COMMIT is entered; next grant goes to the other requester.
REQ-039 flush_i and csr_commit_i asserted in the same WAIT_COMMIT cycle -> IDLE, rr_q unchanged, so the same requester wins again.
REQ-040 rst_i asserted during WAIT_COMMIT -> all outputs 0 next cycle; first grant after reset goes to requester 0.

Source files
------------

// File: rtl/csr_arbiter.sv
// Round-robin arbiter that funnels several CSR requesters into a single-entry CSR buffer.
// Only one op is outstanding at a time; a watchdog abandons ops whose commit never arrives.
module csr_arbiter #(
    parameter int NR_REQ  = 2,
    parameter int XLEN    = 64,
    parameter int TIMEOUT = 64
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      flush_i,
    input  logic [NR_REQ-1:0]         req_valid_i,
    output logic [NR_REQ-1:0]         req_ready_o,
    input  logic [NR_REQ*12-1:0]      req_addr_i,
    input  logic [NR_REQ*XLEN-1:0]    req_wdata_i,
    output logic                      csr_valid_o,
    input  logic                      csr_ready_i,
    output logic [11:0]               csr_addr_o,
    output logic [XLEN-1:0]           csr_wdata_o,
    input  logic                      csr_commit_i,
    output logic [$clog2(NR_REQ)-1:0] grant_id_o,
    output logic                      busy_o,
    output logic                      timeout_o
);

    localparam int IDW = $clog2(NR_REQ);
    localparam int WDW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_COMMIT
    } state_e;

    state_e           state_q, state_d;
    logic [IDW-1:0]   rr_q, rr_d;
    logic [WDW-1:0]   wd_q, wd_d;
    logic             hold_q;
    logic             expire;

    logic             pick_vld;
    logic [IDW-1:0]   pick_id;
    logic [IDW-1:0]   idx;
    logic [11:0]      pick_addr;
    logic [XLEN-1:0]  pick_wdata;
    logic             accept;

    logic [11:0]      addr_p1;
    logic [XLEN-1:0]  wdata_p1;
    logic [IDW-1:0]   owner_p1;

    function automatic logic [IDW-1:0] wrap_inc(input logic [IDW-1:0] v);
        if (v == IDW'(NR_REQ - 1)) begin
            return '0;
        end
        return v + 1'b1;
    endfunction

    function automatic logic [NR_REQ-1:0] onehot(input logic [IDW-1:0] id);
        logic [NR_REQ-1:0] r;
        r     = '0;
        r[id] = 1'b1;
        return r;
    endfunction

    // Arbitration: first valid requester at or above rr_q, wrapping around.
    always_comb begin
        pick_vld = 1'b0;
        pick_id  = '0;
        idx      = rr_q;
        for (int k = 0; k < NR_REQ; k++) begin
            if (!pick_vld && req_valid_i[idx]) begin
                pick_vld = 1'b1;
                pick_id  = idx;
            end
            idx = wrap_inc(idx);
        end
    end

    always_comb begin
        pick_addr  = '0;
        pick_wdata = '0;
        for (int k = 0; k < NR_REQ; k++) begin
            if (pick_id == IDW'(k)) begin
                pick_addr  = req_addr_i[k*12 +: 12];
                pick_wdata = req_wdata_i[k*XLEN +: XLEN];
            end
        end
    end

    // hold_q keeps the arbiter from granting in the first cycle out of reset.
    assign accept = (state_q == IDLE) && !hold_q && !flush_i && !rst_i && pick_vld;

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        wd_d    = wd_q;
        expire  = 1'b0;
        if (flush_i) begin
            state_d = IDLE;
            wd_d    = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_d = ISSUE;
                    end
                end
                ISSUE: begin
                    if (csr_ready_i) begin
                        state_d = WAIT_COMMIT;
                        wd_d    = '0;
                    end
                end
                WAIT_COMMIT: begin
                    if (csr_commit_i) begin
                        state_d = IDLE;
                        rr_d    = wrap_inc(owner_p1);
                    end else if (wd_q == WDW'(TIMEOUT - 1)) begin
                        state_d = IDLE;
                        rr_d    = wrap_inc(owner_p1);
                        expire  = 1'b1;
                    end else begin
                        wd_d = wd_q + 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            rr_q    <= '0;
            wd_q    <= '0;
            hold_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            wd_q    <= wd_d;
            hold_q  <= 1'b0;
        end
    end

    // Stage p1: op captured at acceptance, held until the next acceptance.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            addr_p1  <= '0;
            wdata_p1 <= '0;
            owner_p1 <= '0;
        end else if (accept) begin
            addr_p1  <= pick_addr;
            wdata_p1 <= pick_wdata;
            owner_p1 <= pick_id;
        end
    end

    // Outputs are masked while reset is asserted so nothing stale leaks out.
    assign req_ready_o = accept ? onehot(pick_id) : '0;
    assign csr_valid_o = !rst_i && (state_q == ISSUE);
    assign busy_o      = !rst_i && (state_q != IDLE);
    assign timeout_o   = !rst_i && expire;
    assign csr_addr_o  = rst_i ? '0 : addr_p1;
    assign csr_wdata_o = rst_i ? '0 : wdata_p1;
    assign grant_id_o  = rst_i ? '0 : owner_p1;

    a_ready_onehot: assert property (@(posedge clk_i) disable iff (rst_i)
        $onehot0(req_ready_o));
    a_ready_idle: assert property (@(posedge clk_i) disable iff (rst_i)
        (|req_ready_o) |-> (state_q == IDLE));
    a_wd_range: assert property (@(posedge clk_i) disable iff (rst_i)
        (state_q == WAIT_COMMIT) |-> (wd_q <= WDW'(TIMEOUT - 1)));

endmodule
